// File: rtl/time_param_programmer.sv
// Writes up to four 4-bit interval values into the controller's time-parameter store
// using a setup / held-strobe / recovery-gap handshake. Optional MIN_CLAMP_EN writes a latched 0 as 1.
module time_param_programmer #(
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        clock,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [15:0] Values,
  input  logic [3:0]  Write_Mask,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  Time_Parameter,
  output logic [3:0]  Time_Value,
  output logic        Reprogram
);

  localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ?
                           ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES) :
                           ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP,
    FINISH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      values_q;
  logic [3:0]       mask_q;
  logic [2:0]       first_set;
  logic [2:0]       next_set;

  // Lowest set mask bit at or above 'from'; MSB of the result flags that one was found.
  function automatic logic [2:0] find_set(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  function automatic logic [3:0] sel_value(input logic [15:0] vals, input logic [1:0] idx);
    logic [3:0] v;
    v = vals[{idx, 2'b00} +: 4];
`ifdef MIN_CLAMP_EN
    if (v == 4'd0) v = 4'd1;
`else
    v = v;
`endif
    return v;
  endfunction

  assign first_set = find_set(Write_Mask, 3'd0);
  assign next_set  = find_set(mask_q, {1'b0, Time_Parameter} + 3'd1);

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      values_q       <= '0;
      mask_q         <= '0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Time_Parameter <= '0;
      Time_Value     <= '0;
      Reprogram      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            values_q <= Values;
            mask_q   <= Write_Mask;
            if (first_set[2]) begin
              state          <= SETUP;
              Busy           <= 1'b1;
              cnt            <= SETUP_LD;
              Time_Parameter <= first_set[1:0];
              Time_Value     <= sel_value(Values, first_set[1:0]);
            end else begin
              state <= FINISH;
              Done  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state     <= STROBE;
            Reprogram <= 1'b1;
            cnt       <= HOLD_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state     <= GAP;
            Reprogram <= 1'b0;
            cnt       <= GAP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          // Data stays put through the gap; the next index is loaded only on entering SETUP.
          if (cnt == '0) begin
            if (next_set[2]) begin
              state          <= SETUP;
              cnt            <= SETUP_LD;
              Time_Parameter <= next_set[1:0];
              Time_Value     <= sel_value(values_q, next_set[1:0]);
            end else begin
              state <= FINISH;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FINISH: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          Done      <= 1'b0;
          Reprogram <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_param_programmer.sv
// Directed bench for time_param_programmer: expected strobe schedule derived from
// setup=2 / hold=4 / gap=4 cycles per write, ascending index order.
module tb_time_param_programmer;

  logic        clk;
  logic        Reset_n;
  logic        Start;
  logic [15:0] Values;
  logic [3:0]  Write_Mask;
  logic        Busy;
  logic        Done;
  logic [1:0]  Time_Parameter;
  logic [3:0]  Time_Value;
  logic        Reprogram;

  int checks = 0;
  int errors = 0;

  time_param_programmer dut (
    .clock          (clk),
    .Reset_n        (Reset_n),
    .Start          (Start),
    .Values         (Values),
    .Write_Mask     (Write_Mask),
    .Busy           (Busy),
    .Done           (Done),
    .Time_Parameter (Time_Parameter),
    .Time_Value     (Time_Value),
    .Reprogram      (Reprogram)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_value(input logic [3:0] v);
`ifdef MIN_CLAMP_EN
    return (v == 4'd0) ? 4'd1 : v;
`else
    return v;
`endif
  endfunction

  // Start a sequence at cycle 0 and check cycles 1..ncyc. A non-zero rp_cyc re-pulses
  // Start with rp_vals during that cycle; it must be ignored.
  task automatic run_seq(input logic [15:0] vals, input logic [3:0] mask, input int ncyc,
                         input int rp_cyc, input logic [15:0] rp_vals);
    int idx[4];
    int nw;
    int k;
    int ph;
    int kk;
    logic e_busy;
    logic e_done;
    logic e_rep;
    logic [1:0] ep;
    logic [3:0] ev;
    nw = 0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = 0;
      if (mask[i]) begin
        idx[nw] = i;
        nw++;
      end
    end
    @(negedge clk);
    Values     = vals;
    Write_Mask = mask;
    Start      = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      k      = (c - 1) / 10;
      ph     = (c - 1) % 10;
      e_busy = (nw > 0) && (c <= 10 * nw);
      e_done = (nw == 0) ? (c == 1) : (c == 10 * nw + 1);
      e_rep  = e_busy && (ph >= 2) && (ph <= 5);
      chk("busy", c, 32'(Busy), 32'(e_busy));
      chk("done", c, 32'(Done), 32'(e_done));
      chk("reprogram", c, 32'(Reprogram), 32'(e_rep));
      if ((nw > 0) && (c <= 10 * nw + 1)) begin
        kk = e_busy ? k : nw - 1;
        ep = 2'(idx[kk]);
        ev = exp_value(vals[4 * idx[kk] +: 4]);
        chk("time_parameter", c, 32'(Time_Parameter), 32'(ep));
        chk("time_value", c, 32'(Time_Value), 32'(ev));
      end
      if (c == rp_cyc) begin
        Start      = 1'b1;
        Values     = rp_vals;
        Write_Mask = 4'hF;
      end else if (c == rp_cyc + 1) begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
  endtask

  initial begin
    Reset_n    = 1'b0;
    Start      = 1'b0;
    Values     = '0;
    Write_Mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 0, 32'(Busy), 32'd0);
    chk("rst_done", 0, 32'(Done), 32'd0);
    chk("rst_reprogram", 0, 32'(Reprogram), 32'd0);
    chk("rst_time_parameter", 0, 32'(Time_Parameter), 32'd0);
    chk("rst_time_value", 0, 32'(Time_Value), 32'd0);
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full mask: strobes 3-6, 13-16, 23-26, 33-36 with (0,6),(1,3),(2,A),(3,5); Done at 41.
    run_seq(16'h5A36, 4'hF, 44, 0, 16'h0000);

    // Sparse mask 1010: (1,8) at 3-6, (3,7) at 13-16; Done at 21.
    run_seq(16'h7080, 4'b1010, 24, 0, 16'h0000);

    // Empty mask: Done at cycle 1, nothing else moves.
    run_seq(16'hFFFF, 4'h0, 4, 0, 16'h0000);

    // Start re-pulsed at cycle 5 with new values: ignored.
    run_seq(16'h5A36, 4'hF, 50, 5, 16'h1111);

    // Reset at cycle 14 in the middle of the second strobe.
    run_seq(16'h5A36, 4'hF, 13, 0, 16'h0000);
    @(posedge clk);
    #1;
    chk("pre_reset_reprogram", 14, 32'(Reprogram), 32'd1);
    chk("pre_reset_time_value", 14, 32'(Time_Value), 32'h3);
    Reset_n = 1'b0;
    #1;
    chk("async_reprogram", 14, 32'(Reprogram), 32'd0);
    chk("async_busy", 14, 32'(Busy), 32'd0);
    chk("async_time_parameter", 14, 32'(Time_Parameter), 32'd0);
    chk("async_time_value", 14, 32'(Time_Value), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold_done", 15 + i, 32'(Done), 32'd0);
      chk("reset_hold_reprogram", 15 + i, 32'(Reprogram), 32'd0);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_done", 0, 32'(Done), 32'd0);
    run_seq(16'h5A36, 4'hF, 44, 0, 16'h0000);

    // Zero value at index 2: clamped to 1 only with MIN_CLAMP_EN.
    run_seq(16'hF0FF, 4'b0100, 14, 0, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
